// File: rtl/bf_pkg.sv
// Shared definitions for the Brainfuck core and its I/O bridge:
// bridge/receiver state encodings, UART frame constants and the opcode set.
package bf_pkg;

    localparam int UART_FRAME_BITS = 10;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE,
        TX,
        RX_WAIT,
        WB
    } bridge_state_t;

    typedef enum logic [1:0] {
        RX_HUNT,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Opcodes as the ASCII characters the core decodes from program memory.
    localparam logic [7:0] OP_INC   = 8'h2B;
    localparam logic [7:0] OP_DEC   = 8'h2D;
    localparam logic [7:0] OP_LEFT  = 8'h3C;
    localparam logic [7:0] OP_RIGHT = 8'h3E;
    localparam logic [7:0] OP_OUT   = 8'h2E;
    localparam logic [7:0] OP_IN    = 8'h2C;
    localparam logic [7:0] OP_LOOP  = 8'h5B;
    localparam logic [7:0] OP_END   = 8'h5D;

endpackage

// File: rtl/bf_io_bridge_if.sv
// Core-side request/response bundle between the Brainfuck core/RAM pair and the I/O bridge.
interface bf_io_bridge_if #(
    parameter int DATA_W = 8
);
    logic              dout;
    logic              din;
    logic [DATA_W-1:0] out_val;
    logic              core_enable;
    logic [DATA_W-1:0] in_val;
    logic              in_we;

    modport master (
        output dout, din, out_val,
        input  core_enable, in_val, in_we
    );

    modport slave (
        input  dout, din, out_val,
        output core_enable, in_val, in_we
    );
endinterface

// File: rtl/bf_uart_rx.sv
// Free-running 8N1 UART receiver: synchroniser, mid-bit sampling, glitch reject on the
// start bit, and a one-cycle valid or frame-error pulse per received frame.
module bf_uart_rx
    import bf_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      valid,
    output logic                      frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic                      rx_meta;
    logic                      rx_sync;
    rx_state_t                 state;
    rx_state_t                 state_next;
    logic [CNT_W-1:0]          cnt;
    logic [CNT_W-1:0]          cnt_next;
    logic [2:0]                bit_idx;
    logic [2:0]                bit_idx_next;
    logic [UART_DATA_BITS-1:0] shift;
    logic [UART_DATA_BITS-1:0] shift_next;
    logic                      valid_next;
    logic                      frame_err_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RX_HUNT;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_idx_next;
            shift     <= shift_next;
            valid     <= valid_next;
            frame_err <= frame_err_next;
        end
    end

    // The start check at half a bit also re-centres the timer so later samples land mid-bit.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt + 1'b1;
        bit_idx_next   = bit_idx;
        shift_next     = shift;
        valid_next     = 1'b0;
        frame_err_next = 1'b0;
        case (state)
            RX_HUNT: begin
                cnt_next = '0;
                if (!rx_sync) begin
                    state_next = RX_START;
                end
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rx_sync ? RX_HUNT : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next     = '0;
                    shift_next   = {rx_sync, shift[UART_DATA_BITS-1:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next       = '0;
                    state_next     = RX_HUNT;
                    valid_next     = rx_sync;
                    frame_err_next = !rx_sync;
                end
            end
            default: state_next = RX_HUNT;
        endcase
    end

    assign data = shift;

endmodule

// File: rtl/bf_io_bridge.sv
// Services the Brainfuck core's '.' and ',' strobes over a UART (8N1), stalling the core
// through core_enable until each request completes.
module bf_io_bridge
    import bf_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic           clk,
    input  logic           rst,
    bf_io_bridge_if.slave  core,
    output logic           uart_tx,
    input  logic           uart_rx,
    output logic           rx_overrun,
    output logic           rx_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       FRAME_END = 4'(UART_FRAME_BITS);

    bridge_state_t     state;
    bridge_state_t     state_next;
    logic              wb_strobe;
    logic [DATA_W+1:0] tx_shift;
    logic [CNT_W-1:0]  tx_cnt;
    logic [3:0]        tx_bits;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ferr;
    logic              rx_full;
    logic [DATA_W-1:0] hold;

    bf_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (uart_rx),
        .data     (rx_data),
        .valid    (rx_valid),
        .frame_err(rx_ferr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // TX is left only once all ten bits have been shifted, so the stop bit gets its full time.
    always_comb begin
        state_next = state;
        wb_strobe  = 1'b0;
        case (state)
            IDLE: begin
                if (core.dout) begin
                    state_next = TX;
                end else if (core.din) begin
                    state_next = RX_WAIT;
                end
            end
            TX: begin
                if (tx_bits == FRAME_END) begin
                    state_next = IDLE;
                end
            end
            RX_WAIT: begin
                if (rx_full) begin
                    state_next = WB;
                end
            end
            WB: begin
                wb_strobe  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign core.core_enable = (state == IDLE) && !core.dout && !core.din;
    assign core.in_we       = wb_strobe;
    assign core.in_val      = hold;

    // uart_tx is registered, so the start bit appears one cycle after the frame is latched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift <= '1;
            tx_cnt   <= '0;
            tx_bits  <= '0;
            uart_tx  <= 1'b1;
        end else begin
            uart_tx <= (state == TX) ? tx_shift[0] : 1'b1;
            if (state == IDLE && core.dout) begin
                tx_shift <= {1'b1, core.out_val, 1'b0};
                tx_cnt   <= '0;
                tx_bits  <= '0;
            end else if (state == TX && tx_bits != FRAME_END) begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt   <= '0;
                    tx_shift <= {1'b1, tx_shift[DATA_W+1:1]};
                    tx_bits  <= tx_bits + 4'd1;
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end
        end
    end

    // A byte landing in the same cycle WB consumes the old one wins and keeps rx_full set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold         <= '0;
            rx_full      <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (rx_valid) begin
                hold    <= rx_data;
                rx_full <= 1'b1;
                if (rx_full && !wb_strobe) begin
                    rx_overrun <= 1'b1;
                end
            end else if (wb_strobe) begin
                rx_full <= 1'b0;
            end
            if (rx_ferr) begin
                rx_frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bf_io_bridge.sv
// Self-checking bench for bf_io_bridge: directed scenarios plus random TX/RX traffic,
// compared against a byte-level model of the frame format and the holding register.
module tb_bf_io_bridge;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_rx = 1'b1;
    logic uart_tx;
    logic rx_overrun;
    logic rx_frame_err;

    int vectors = 0;
    int miscompares = 0;

    logic       model_full;
    logic [7:0] model_byte;
    logic       model_overrun;
    logic       model_ferr;

    bf_io_bridge_if #(.DATA_W(8)) core_bus ();

    bf_io_bridge #(
        .DATA_W(8),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .core        (core_bus),
        .uart_tx     (uart_tx),
        .uart_rx     (uart_rx),
        .rx_overrun  (rx_overrun),
        .rx_frame_err(rx_frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        model_full    = 1'b0;
        model_byte    = 8'h00;
        model_overrun = 1'b0;
        model_ferr    = 1'b0;
    endtask

    task automatic modelReceive(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) begin
            if (model_full) model_overrun = 1'b1;
            model_byte = b;
            model_full = 1'b1;
        end else begin
            model_ferr = 1'b1;
        end
    endtask

    task automatic checkFlags(input string tag);
        checkOutput({tag, "_overrun"}, rx_overrun, model_overrun);
        checkOutput({tag, "_frame_err"}, rx_frame_err, model_ferr);
    endtask

    task automatic driveRxFrame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            uart_rx = frame[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    // Sends one byte on the RX line with the chosen stop bit, then folds it into the model.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
        driveRxFrame(b, stop_bit);
        repeat (8) @(negedge clk);
        modelReceive(b, stop_bit);
    endtask

    task automatic sendDout(input logic [7:0] v);
        logic [9:0]   exp_frame;
        logic [9:0]   got_frame;
        logic [199:0] txs;
        int           low;
        exp_frame = {1'b1, v, 1'b0};
        txs = '1;
        @(negedge clk);
        core_bus.dout = 1'b1;
        core_bus.out_val = v;
        #1 checkOutput("tx_enable_comb", core_bus.core_enable, 1'b0);
        @(negedge clk);
        core_bus.dout = 1'b0;
        core_bus.out_val = 8'($urandom);
        low = 0;
        while (!core_bus.core_enable && low < 200) begin
            txs[low] = uart_tx;
            low++;
            @(negedge clk);
        end
        checkOutput("tx_enable_low_cycles", low, 41);
        if (low >= 41) begin
            checkOutput("tx_lead_idle", txs[0], 1'b1);
            for (int b = 0; b < 10; b++) got_frame[b] = txs[1 + b * CPB + CPB / 2];
            checkOutput("tx_frame", got_frame, exp_frame);
        end
        checkOutput("tx_idle_after", uart_tx, 1'b1);
    endtask

    task automatic readHeld(input logic [7:0] exp);
        @(negedge clk);
        core_bus.din = 1'b1;
        #1 checkOutput("din_enable_comb", core_bus.core_enable, 1'b0);
        @(negedge clk);
        core_bus.din = 1'b0;
        checkOutput("held_we_n0", core_bus.in_we, 1'b0);
        @(negedge clk);
        checkOutput("held_we_n1", core_bus.in_we, 1'b1);
        checkOutput("held_val", core_bus.in_val, exp);
        @(negedge clk);
        checkOutput("held_we_n2", core_bus.in_we, 1'b0);
        checkOutput("held_enable_n2", core_bus.core_enable, 1'b1);
        model_full = 1'b0;
    endtask

    task automatic readWaiting(input logic [7:0] b);
        int   k;
        int   extra;
        logic early;
        fork
            begin
                @(negedge clk);
                core_bus.din = 1'b1;
                @(negedge clk);
                core_bus.din = 1'b0;
                k = 0;
                early = 1'b0;
                while (!core_bus.in_we && k < 400) begin
                    if (core_bus.core_enable) early = 1'b1;
                    k++;
                    @(negedge clk);
                end
                checkOutput("wait_in_we_seen", (k < 400), 1'b1);
                checkOutput("wait_enable_stayed_low", early, 1'b0);
                checkOutput("wait_val", core_bus.in_val, b);
                @(negedge clk);
                checkOutput("wait_we_single", core_bus.in_we, 1'b0);
                checkOutput("wait_enable_back", core_bus.core_enable, 1'b1);
                extra = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (core_bus.in_we) extra++;
                end
                checkOutput("wait_extra_we", extra, 0);
            end
            begin
                repeat (10) @(negedge clk);
                driveRxFrame(b, 1'b1);
            end
        join
    endtask

    initial begin
        logic [7:0] b;
        core_bus.dout = 1'b0;
        core_bus.din = 1'b0;
        core_bus.out_val = 8'h00;
        modelReset();

        repeat (3) @(negedge clk);
        checkOutput("rst_core_enable", core_bus.core_enable, 1'b1);
        checkOutput("rst_in_we", core_bus.in_we, 1'b0);
        checkOutput("rst_in_val", core_bus.in_val, 8'h00);
        checkOutput("rst_uart_tx", uart_tx, 1'b1);
        checkFlags("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        sendDout(8'h41);

        applyStimulus(8'h5A, 1'b1);
        readHeld(model_byte);
        checkFlags("held");

        readWaiting(8'h00);
        checkFlags("waiting");

        // A one-cycle low pulse must not produce a byte: the next real byte must not overrun.
        @(negedge clk);
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (60) @(negedge clk);
        checkFlags("glitch");
        applyStimulus(8'h33, 1'b1);
        checkFlags("after_glitch");
        applyStimulus(8'h77, 1'b0);
        checkFlags("frame_err");
        readHeld(model_byte);

        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        checkFlags("overrun");
        readHeld(model_byte);

        @(negedge clk);
        core_bus.dout = 1'b1;
        core_bus.out_val = 8'hC3;
        @(negedge clk);
        core_bus.dout = 1'b0;
        repeat (13) @(negedge clk);
        #2 rst = 1'b1;
        #1 checkOutput("midtx_rst_uart_tx", uart_tx, 1'b1);
        checkOutput("midtx_rst_enable", core_bus.core_enable, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkFlags("post_rst");
        sendDout(8'hC3);

        for (int it = 0; it < 12; it++) begin
            case ($urandom_range(0, 3))
                0: sendDout(8'($urandom));
                1: begin
                    b = 8'($urandom);
                    applyStimulus(b, 1'b1);
                    readHeld(model_byte);
                end
                2: readWaiting(8'($urandom));
                default: begin
                    applyStimulus(8'($urandom), 1'b1);
                    applyStimulus(8'($urandom), 1'b1);
                    readHeld(model_byte);
                end
            endcase
            checkFlags("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bf_io_bridge.md
# bf_io_bridge

Responder for the Brainfuck core's `.`/`,` request strobes. Services each `dout` by serialising the current cell value onto a UART TX line (8N1). Services each `din` by delivering a byte received on UART RX back to the RAM cell. Stalls the core through its `enable` input until the request completes, and sits between the core/RAM pair and the board UART pins.

## Interface
Parameters:
- `DATA_W`, 8: cell width; only 8 is supported, since the UART frame is 8 data bits.
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200); legal range ≥ 4.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `dout`  in  1  one-cycle output request from the core.
- `din`  in  1  one-cycle input request from the core.
- `out_val`  in  DATA_W  cell value; valid in the cycle `dout`=1.
- `core_enable`  out  1  drives the core's `enable`; low while a request is pending or in service.
- `in_val`  out  DATA_W  received byte for the RAM cell.
- `in_we`  out  1  one-cycle write strobe for `in_val` into the current cell.
- `uart_tx`  out  1  serial out, idle high.
- `uart_rx`  in  1  serial in, asynchronous to `clk`.
- `rx_overrun`  out  1  sticky; a received byte was lost.
- `rx_frame_err`  out  1  sticky; a received frame had a low stop bit.

## Operation
- Top FSM states: `IDLE`, `TX`, `RX_WAIT`, `WB`.
  - `IDLE` + `dout` → latch `out_val` into the TX shift register and go to `TX`.
  - `IDLE` + `din` → go to `RX_WAIT`.
  - If `dout` and `din` are both high, `dout` wins and `din` is ignored (the core never issues both).
  - `TX` → `IDLE` when the stop bit completes.
  - `RX_WAIT` → `WB` when `rx_full`=1.
  - `WB` → `IDLE` after one cycle. In `WB`: `in_we`=1, `in_val` = holding byte, `rx_full` cleared.
- `core_enable` is combinational: `(state==IDLE) && !dout && !din`. The core is therefore frozen in the same cycle it raises a strobe.
- TX frame: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly `CLKS_PER_BIT` cycles.
- RX path runs continuously, independent of the top FSM:
  - 2-flop synchroniser on `uart_rx`.
  - A falling edge starts the bit timer.
  - Start bit is re-checked at `CLKS_PER_BIT/2`; if high, the edge is a glitch and the receiver returns to hunting.
  - Data bits are sampled at mid-bit. Stop bit is sampled at mid-bit.
  - Stop=1 → byte goes to the 1-byte holding register and `rx_full` is set.
  - Stop=0 → byte is discarded and `rx_frame_err` is set.
- Holding register: a byte arriving while `rx_full`=1 and not consumed in the same cycle overwrites the register and sets `rx_overrun`. If `WB` consumes in the same cycle a new byte lands, the new byte is kept and `rx_full` stays 1.
- Sticky flags clear only on `rst`.
- Reset mid-frame aborts TX/RX immediately; `uart_tx` returns high.

## Timing
- Reset values:
  - `core_enable`=1, `in_we`=0, `in_val`=0, `uart_tx`=1.
  - `rx_overrun`=0, `rx_frame_err`=0.
  - FSM=`IDLE`, `rx_full`=0.
- TX: `dout` sampled at edge N; `uart_tx` falls after edge N+1. The frame occupies 10·`CLKS_PER_BIT` cycles. `core_enable` returns high in the cycle after the stop bit ends.
- RX with byte already held: `din` at edge N → `in_we`=1 during cycle N+1 → `core_enable`=1 from cycle N+2.
- RX without a held byte: `in_we` asserts 1 cycle after `rx_full` sets. Receive latency from the start edge is ≈ 9.5·`CLKS_PER_BIT` + 3 cycles (synchroniser + register).
- `in_we` is never high for more than one cycle per `din`.

## Structure
- Shared package `bf_pkg`: FSM state enum, `UART_FRAME_BITS`=10, and the opcode constants already used by the core.
- One sub-module, `bf_uart_rx`: synchroniser, bit timer, deserialiser, and frame-error detection. Its outputs are a byte and a one-cycle valid.
- TX serialiser and holding register stay in the top module.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- `dout` with `out_val`=0x41 → `uart_tx` shows 0,1,0,0,0,0,0,1,0,1 at 4 cycles/bit; `core_enable` low for 41 cycles.
- Byte 0x5A sent on RX, then `din` → `in_we` pulses once, 1 cycle later, with `in_val`=0x5A; `core_enable` high 2 cycles after `din`.
- `din` first, then byte 0x00 → `core_enable` stays low until `in_we` with `in_val`=0x00; no spurious extra `in_we`.
- Two bytes 0x11, 0x22 with no `din` → `rx_overrun`=1; next `din` returns 0x22.
- 1-cycle low glitch on `uart_rx` → no byte, no flags. A frame with stop=0 → `rx_frame_err`=1, `rx_full` unchanged.
- `rst` asserted mid-TX, on bit 3 → `uart_tx`=1 and `core_enable`=1 immediately; the next `dout` sends a full, clean frame.
